// File: rtl/rename_alloc_stage.sv
// Rename/allocate stage: speculative RAT lookup, free-list pop for the destination and a registered
// renamed-uop output, plus a registered return path for committed old physical registers.
// Optional macro RENAME_COMMIT_RAT_EN adds a committed RAT that the speculative RAT restores from on flush.
module rename_alloc_stage #(
    parameter int ARCH_W     = 5,
    parameter int PHYS_W     = 6,
    parameter int NUM_COMMIT = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 flush_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [ARCH_W-1:0]                    in_rs1_i,
    input  logic [ARCH_W-1:0]                    in_rs2_i,
    input  logic [ARCH_W-1:0]                    in_rd_i,
    input  logic                                 in_rd_wr_i,
    output logic                                 fl_rd_en_o,
    input  logic [PHYS_W-1:0]                    fl_rd_data_i,
    input  logic                                 fl_empty_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [PHYS_W-1:0]                    out_prs1_o,
    output logic [PHYS_W-1:0]                    out_prs2_o,
    output logic [PHYS_W-1:0]                    out_prd_o,
    output logic [PHYS_W-1:0]                    out_old_prd_o,
    output logic                                 out_rd_wr_o,
    input  logic [NUM_COMMIT-1:0]                commit_valid_i,
    input  logic [NUM_COMMIT-1:0]                commit_rd_wr_i,
    input  logic [NUM_COMMIT-1:0][ARCH_W-1:0]    commit_ard_i,
    input  logic [NUM_COMMIT-1:0][PHYS_W-1:0]    commit_prd_i,
    input  logic [NUM_COMMIT-1:0][PHYS_W-1:0]    commit_old_prd_i,
    output logic [NUM_COMMIT-1:0]                fl_wr_en_o,
    output logic [NUM_COMMIT-1:0][PHYS_W-1:0]    fl_wr_data_o
);

    localparam int NUM_ARCH = 1 << ARCH_W;

    logic [PHYS_W-1:0] rat_q [NUM_ARCH];
    logic [PHYS_W-1:0] rat_d [NUM_ARCH];

    logic              outValid_q, outValid_d;
    logic [PHYS_W-1:0] outPrs1_q, outPrs1_d;
    logic [PHYS_W-1:0] outPrs2_q, outPrs2_d;
    logic [PHYS_W-1:0] outPrd_q, outPrd_d;
    logic [PHYS_W-1:0] outOldPrd_q, outOldPrd_d;
    logic              outRdWr_q, outRdWr_d;

    logic [NUM_COMMIT-1:0]             flWrEn_q, flWrEn_d;
    logic [NUM_COMMIT-1:0][PHYS_W-1:0] flWrData_q;

    logic accept;
    logic alloc;
    logic [NUM_COMMIT-1:0] commitFree;

    // Stall is conservative: an empty free list blocks even instructions that need no destination.
    assign in_ready_o = (!outValid_q || out_ready_i) && !fl_empty_i && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign alloc      = accept && in_rd_wr_i && (in_rd_i != '0);
    assign fl_rd_en_o = alloc;

    always_comb begin
        for (int l = 0; l < NUM_COMMIT; l++) begin
            commitFree[l] = commit_valid_i[l] && commit_rd_wr_i[l] && (commit_ard_i[l] != '0);
        end
    end

`ifdef RENAME_COMMIT_RAT_EN
    logic [PHYS_W-1:0] crat_q [NUM_ARCH];
    logic [PHYS_W-1:0] crat_d [NUM_ARCH];

    // Later lanes overwrite earlier ones, so the youngest commit to an arch reg wins.
    always_comb begin
        crat_d = crat_q;
        for (int l = 0; l < NUM_COMMIT; l++) begin
            if (commitFree[l]) begin
                crat_d[commit_ard_i[l]] = commit_prd_i[l];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) crat_q[i] <= PHYS_W'(i);
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) crat_q[i] <= crat_d[i];
        end
    end

    // Flush restores the committed view, including commits retiring in the flush cycle.
    always_comb begin
        rat_d = rat_q;
        if (flush_i) begin
            rat_d = crat_d;
        end else if (alloc) begin
            rat_d[in_rd_i] = fl_rd_data_i;
        end
    end
`else
    logic unusedCommitPrd;
    assign unusedCommitPrd = ^commit_prd_i;

    always_comb begin
        rat_d = rat_q;
        if (alloc) begin
            rat_d[in_rd_i] = fl_rd_data_i;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= PHYS_W'(i);
        end else begin
            for (int i = 0; i < NUM_ARCH; i++) rat_q[i] <= rat_d[i];
        end
    end

    // Sources read the RAT before this cycle's write, so rs==rd sees the previous mapping.
    always_comb begin
        outValid_d  = outValid_q;
        outPrs1_d   = outPrs1_q;
        outPrs2_d   = outPrs2_q;
        outPrd_d    = outPrd_q;
        outOldPrd_d = outOldPrd_q;
        outRdWr_d   = outRdWr_q;
        if (flush_i) begin
            outValid_d = 1'b0;
        end else if (accept) begin
            outValid_d = 1'b1;
            outPrs1_d  = rat_q[in_rs1_i];
            outPrs2_d  = rat_q[in_rs2_i];
            if (alloc) begin
                outPrd_d    = fl_rd_data_i;
                outOldPrd_d = rat_q[in_rd_i];
                outRdWr_d   = 1'b1;
            end else begin
                outPrd_d    = '0;
                outOldPrd_d = '0;
                outRdWr_d   = 1'b0;
            end
        end else if (out_ready_i) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outValid_q  <= 1'b0;
            outPrs1_q   <= '0;
            outPrs2_q   <= '0;
            outPrd_q    <= '0;
            outOldPrd_q <= '0;
            outRdWr_q   <= 1'b0;
        end else begin
            outValid_q  <= outValid_d;
            outPrs1_q   <= outPrs1_d;
            outPrs2_q   <= outPrs2_d;
            outPrd_q    <= outPrd_d;
            outOldPrd_q <= outOldPrd_d;
            outRdWr_q   <= outRdWr_d;
        end
    end

    assign flWrEn_d = commitFree;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flWrEn_q   <= '0;
            flWrData_q <= '0;
        end else begin
            flWrEn_q   <= flWrEn_d;
            flWrData_q <= commit_old_prd_i;
        end
    end

    assign out_valid_o   = outValid_q;
    assign out_prs1_o    = outPrs1_q;
    assign out_prs2_o    = outPrs2_q;
    assign out_prd_o     = outPrd_q;
    assign out_old_prd_o = outOldPrd_q;
    assign out_rd_wr_o   = outRdWr_q;
    assign fl_wr_en_o    = flWrEn_q;
    assign fl_wr_data_o  = flWrData_q;

endmodule

// File: tb/tb_rename_alloc_stage.sv
// Testbench for rename_alloc_stage: directed vector table, hand sequences and a randomized run
// against an array-based rename model (honours RENAME_COMMIT_RAT_EN).
module tb_rename_alloc_stage;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [4:0]       in_rs1_i, in_rs2_i, in_rd_i;
    logic             in_rd_wr_i;
    logic             fl_rd_en_o;
    logic [5:0]       fl_rd_data_i;
    logic             fl_empty_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [5:0]       out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o;
    logic             out_rd_wr_o;
    logic [1:0]       commit_valid_i, commit_rd_wr_i;
    logic [1:0][4:0]  commit_ard_i;
    logic [1:0][5:0]  commit_prd_i, commit_old_prd_i;
    logic [1:0]       fl_wr_en_o;
    logic [1:0][5:0]  fl_wr_data_o;

    rename_alloc_stage dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_rs1_i(in_rs1_i), .in_rs2_i(in_rs2_i), .in_rd_i(in_rd_i), .in_rd_wr_i(in_rd_wr_i),
        .fl_rd_en_o(fl_rd_en_o), .fl_rd_data_i(fl_rd_data_i), .fl_empty_i(fl_empty_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_prs1_o(out_prs1_o), .out_prs2_o(out_prs2_o), .out_prd_o(out_prd_o),
        .out_old_prd_o(out_old_prd_o), .out_rd_wr_o(out_rd_wr_o),
        .commit_valid_i(commit_valid_i), .commit_rd_wr_i(commit_rd_wr_i),
        .commit_ard_i(commit_ard_i), .commit_prd_i(commit_prd_i),
        .commit_old_prd_i(commit_old_prd_i),
        .fl_wr_en_o(fl_wr_en_o), .fl_wr_data_o(fl_wr_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        int       rs1, rs2, rd;
        bit       rdWr;
        int       flData;
        bit       flEmpty, outReady, flush;
        bit [1:0] cValid, cRdWr;
        int       ard0, ard1, prd0, prd1, old0, old1;
        bit       hasExp;
        bit       eReady, eRdEn, eValid, eRdWr;
        int       ePrs1, ePrs2, ePrd, eOld;
        bit [1:0] eFlWrEn;
        int       eFl0, eFl1;
    } vec_t;

    int vectors = 0;
    int checks = 0;
    int miscompares = 0;

    // Reference model: plain arrays for the speculative and committed maps.
    int mRat[32];
    int mCrat[32];
    bit mOutValid, mRdWr;
    int mPrs1, mPrs2, mPrd, mOld;
    bit [1:0] mFlEn;
    int mFl0, mFl1;

    function automatic void resetModel();
        for (int i = 0; i < 32; i++) begin
            mRat[i]  = i;
            mCrat[i] = i;
        end
        mOutValid = 0; mRdWr = 0;
        mPrs1 = 0; mPrs2 = 0; mPrd = 0; mOld = 0;
        mFlEn = 2'b00; mFl0 = 0; mFl1 = 0;
    endfunction

    function automatic vec_t ren(bit v, int rs1, int rs2, int rd, bit rdWr, int fl,
                                 bit flEmpty, bit outReady);
        vec_t x;
        x.valid = v; x.rs1 = rs1; x.rs2 = rs2; x.rd = rd; x.rdWr = rdWr; x.flData = fl;
        x.flEmpty = flEmpty; x.outReady = outReady; x.flush = 0;
        x.cValid = 2'b00; x.cRdWr = 2'b00;
        x.ard0 = 0; x.ard1 = 0; x.prd0 = 0; x.prd1 = 0; x.old0 = 0; x.old1 = 0;
        x.hasExp = 0; x.eReady = 0; x.eRdEn = 0; x.eValid = 0; x.eRdWr = 0;
        x.ePrs1 = 0; x.ePrs2 = 0; x.ePrd = 0; x.eOld = 0;
        x.eFlWrEn = 2'b00; x.eFl0 = 0; x.eFl1 = 0;
        return x;
    endfunction

    function automatic vec_t com(vec_t x, bit [1:0] cv, bit [1:0] rw, int a0, int a1,
                                 int p0, int p1, int o0, int o1);
        vec_t y = x;
        y.cValid = cv; y.cRdWr = rw;
        y.ard0 = a0; y.ard1 = a1; y.prd0 = p0; y.prd1 = p1; y.old0 = o0; y.old1 = o1;
        return y;
    endfunction

    function automatic vec_t expR(vec_t x, bit rdy, bit rdEn, bit valid, int p1, int p2,
                                  int prd, int old, bit rw);
        vec_t y = x;
        y.hasExp = 1; y.eReady = rdy; y.eRdEn = rdEn; y.eValid = valid;
        y.ePrs1 = p1; y.ePrs2 = p2; y.ePrd = prd; y.eOld = old; y.eRdWr = rw;
        return y;
    endfunction

    function automatic vec_t expF(vec_t x, bit [1:0] en, int d0, int d1);
        vec_t y = x;
        y.eFlWrEn = en; y.eFl0 = d0; y.eFl1 = d1;
        return y;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        flush_i = 0; in_valid_i = 0; in_rs1_i = 0; in_rs2_i = 0; in_rd_i = 0; in_rd_wr_i = 0;
        fl_rd_data_i = 0; fl_empty_i = 0; out_ready_i = 1;
        commit_valid_i = 0; commit_rd_wr_i = 0; commit_ard_i = '0; commit_prd_i = '0;
        commit_old_prd_i = '0;
    endtask

    // One clock of stimulus: check combinational outputs, advance the model, check registers.
    task automatic applyStimulus(input vec_t s);
        bit expReady, accept, alloc;
        flush_i = s.flush; in_valid_i = s.valid;
        in_rs1_i = 5'(s.rs1); in_rs2_i = 5'(s.rs2); in_rd_i = 5'(s.rd); in_rd_wr_i = s.rdWr;
        fl_rd_data_i = 6'(s.flData); fl_empty_i = s.flEmpty; out_ready_i = s.outReady;
        commit_valid_i = s.cValid; commit_rd_wr_i = s.cRdWr;
        commit_ard_i[0] = 5'(s.ard0); commit_ard_i[1] = 5'(s.ard1);
        commit_prd_i[0] = 6'(s.prd0); commit_prd_i[1] = 6'(s.prd1);
        commit_old_prd_i[0] = 6'(s.old0); commit_old_prd_i[1] = 6'(s.old1);
        #1;
        expReady = (!mOutValid || s.outReady) && !s.flEmpty && !s.flush;
        accept   = s.valid && expReady;
        alloc    = accept && s.rdWr && (s.rd != 0);
        checkOutput("in_ready", in_ready_o, expReady);
        checkOutput("fl_rd_en", fl_rd_en_o, alloc);
        if (s.hasExp) begin
            checkOutput("tbl_in_ready", in_ready_o, s.eReady);
            checkOutput("tbl_fl_rd_en", fl_rd_en_o, s.eRdEn);
        end

        mFlEn[0] = s.cValid[0] && s.cRdWr[0] && (s.ard0 != 0);
        mFlEn[1] = s.cValid[1] && s.cRdWr[1] && (s.ard1 != 0);
        mFl0 = s.old0;
        mFl1 = s.old1;
`ifdef RENAME_COMMIT_RAT_EN
        if (mFlEn[0]) mCrat[s.ard0] = s.prd0;
        if (mFlEn[1]) mCrat[s.ard1] = s.prd1;
`endif
        if (s.flush) begin
            mOutValid = 0;
`ifdef RENAME_COMMIT_RAT_EN
            for (int i = 0; i < 32; i++) mRat[i] = mCrat[i];
`endif
        end else if (accept) begin
            mOutValid = 1;
            mPrs1 = mRat[s.rs1];
            mPrs2 = mRat[s.rs2];
            if (alloc) begin
                mPrd = s.flData; mOld = mRat[s.rd]; mRdWr = 1;
                mRat[s.rd] = s.flData;
            end else begin
                mPrd = 0; mOld = 0; mRdWr = 0;
            end
        end else if (s.outReady) begin
            mOutValid = 0;
        end

        @(posedge clk);
        #1;
        checkOutput("out_valid", out_valid_o, mOutValid);
        if (mOutValid) begin
            checkOutput("out_prs1", out_prs1_o, mPrs1);
            checkOutput("out_prs2", out_prs2_o, mPrs2);
            checkOutput("out_prd", out_prd_o, mPrd);
            checkOutput("out_old_prd", out_old_prd_o, mOld);
            checkOutput("out_rd_wr", out_rd_wr_o, mRdWr);
        end
        checkOutput("fl_wr_en", fl_wr_en_o, mFlEn);
        checkOutput("fl_wr_data0", fl_wr_data_o[0], mFl0);
        checkOutput("fl_wr_data1", fl_wr_data_o[1], mFl1);
        if (s.hasExp) begin
            checkOutput("tbl_out_valid", out_valid_o, s.eValid);
            if (s.eValid) begin
                checkOutput("tbl_out_prs1", out_prs1_o, s.ePrs1);
                checkOutput("tbl_out_prs2", out_prs2_o, s.ePrs2);
                checkOutput("tbl_out_prd", out_prd_o, s.ePrd);
                checkOutput("tbl_out_old_prd", out_old_prd_o, s.eOld);
                checkOutput("tbl_out_rd_wr", out_rd_wr_o, s.eRdWr);
            end
            checkOutput("tbl_fl_wr_en", fl_wr_en_o, s.eFlWrEn);
            checkOutput("tbl_fl_wr_data0", fl_wr_data_o[0], s.eFl0);
            checkOutput("tbl_fl_wr_data1", fl_wr_data_o[1], s.eFl1);
        end
        vectors++;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        int flushRs1, flushRs2;

        // Directed vectors with hand-derived expectations.
        tbl.push_back(expR(ren(1, 3, 4, 5, 1, 32, 0, 1), 1, 1, 1, 3, 4, 32, 5, 1));
        tbl.push_back(expR(ren(1, 5, 0, 5, 1, 33, 0, 1), 1, 1, 1, 32, 0, 33, 32, 1));
        tbl.push_back(expR(ren(1, 5, 6, 0, 1, 40, 0, 1), 1, 0, 1, 33, 6, 0, 0, 0));
        tbl.push_back(expR(ren(1, 5, 7, 9, 0, 41, 0, 1), 1, 0, 1, 33, 7, 0, 0, 0));
        tbl.push_back(expR(ren(0, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(expR(ren(1, 9, 5, 9, 1, 42, 1, 1), 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(expR(ren(1, 9, 5, 9, 1, 42, 0, 1), 1, 1, 1, 9, 33, 42, 9, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(expR(ren(1, 1, 2, 10, 1, 43, 0, 0), 0, 0, 1, 9, 33, 42, 9, 1));
        tbl.push_back(expR(ren(0, 0, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(expF(expR(com(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'b11, 2'b11, 1, 2, 20, 21, 7, 9),
                                1, 0, 0, 0, 0, 0, 0, 0), 2'b11, 7, 9));
        tbl.push_back(expF(expR(com(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'b11, 2'b11, 0, 3, 22, 23, 11, 12),
                                1, 0, 0, 0, 0, 0, 0, 0), 2'b10, 11, 12));
        tbl.push_back(expF(expR(com(ren(0, 0, 0, 0, 0, 0, 0, 1), 2'b01, 2'b00, 4, 0, 24, 0, 0, 0),
                                1, 0, 0, 0, 0, 0, 0, 0), 2'b00, 0, 0));

        resetModel();
        clearInputs();
        reset = 1;
        #2;
        checkOutput("rst_out_valid", out_valid_o, 0);
        #10;
        checkOutput("rst_out_prs1", out_prs1_o, 0);
        checkOutput("rst_out_prs2", out_prs2_o, 0);
        checkOutput("rst_out_prd", out_prd_o, 0);
        checkOutput("rst_out_old_prd", out_old_prd_o, 0);
        checkOutput("rst_out_rd_wr", out_rd_wr_o, 0);
        checkOutput("rst_fl_wr_en", fl_wr_en_o, 0);
        checkOutput("rst_fl_wr_data", fl_wr_data_o, 0);
        checkOutput("rst_fl_rd_en", fl_rd_en_o, 0);
        reset = 0;

        foreach (tbl[i]) applyStimulus(tbl[i]);

        // Flush sequence: held uop is dropped; sources after flush come from the committed map when enabled.
`ifdef RENAME_COMMIT_RAT_EN
        flushRs1 = 40; flushRs2 = 44;
`else
        flushRs1 = 50; flushRs2 = 6;
`endif
        applyStimulus(expR(ren(1, 0, 0, 5, 1, 50, 0, 1), 1, 1, 1, 0, 0, 50, 33, 1));
        applyStimulus(expF(expR(com(ren(0, 0, 0, 0, 0, 0, 0, 0), 2'b01, 2'b01, 5, 0, 40, 0, 33, 0),
                                0, 0, 1, 0, 0, 50, 33, 1), 2'b01, 33, 0));
        v = com(ren(1, 1, 1, 8, 1, 51, 0, 0), 2'b10, 2'b10, 0, 6, 0, 44, 0, 6);
        v.flush = 1;
        applyStimulus(expF(expR(v, 0, 0, 0, 0, 0, 0, 0, 0), 2'b10, 0, 6));
        applyStimulus(expR(ren(1, 5, 6, 0, 0, 0, 0, 1), 1, 0, 1, flushRs1, flushRs2, 0, 0, 0));

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            v = ren(($urandom_range(0, 3) != 0), $urandom_range(0, 31), $urandom_range(0, 31),
                    ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31),
                    ($urandom_range(0, 3) != 0), $urandom_range(0, 63),
                    ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) < 7));
            v.flush = ($urandom_range(0, 19) == 0);
            v = com(v, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    $urandom_range(0, 31), $urandom_range(0, 31),
                    $urandom_range(0, 63), $urandom_range(0, 63),
                    $urandom_range(0, 63), $urandom_range(0, 63));
            applyStimulus(v);
        end

        // Reset while a uop is held discards it and restores identity mapping.
        applyStimulus(ren(1, 2, 3, 7, 1, 60, 0, 0));
        applyStimulus(ren(0, 0, 0, 0, 0, 0, 0, 0));
        clearInputs();
        reset = 1;
        #2;
        checkOutput("midrst_out_valid", out_valid_o, 0);
        checkOutput("midrst_fl_wr_en", fl_wr_en_o, 0);
        #1;
        reset = 0;
        resetModel();
        applyStimulus(expR(ren(1, 7, 5, 0, 0, 0, 0, 1), 1, 0, 1, 7, 5, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rename_alloc_stage.md
Name: rename_alloc_stage

Overview:
- Register-rename allocation stage that sits directly upstream of and around the physical-register free-list FIFO (rd_en/rd_data/empty pop side, 2-wide push side).
- Each cycle it renames at most one decoded instruction: it looks up source mappings in a speculative RAT and pops a free physical register for the destination.
- It emits a registered renamed uop with a valid/ready handshake.
- It returns committed old physical registers to the free list through up to 2 registered write lanes.

Parameters:
- ARCH_W, 5, architectural register index width (32 arch regs).
- PHYS_W, 6, physical register index width (64 phys regs); free list is preloaded with 32..63 outside this block.
- NUM_COMMIT, 2, commit/free lanes per cycle; must equal free-list MAX_NUM_OF_WRITES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  pipeline flush (sync).
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage can accept.
- in_rs1, in_rs2  in  ARCH_W  source arch regs.
- in_rd  in  ARCH_W  dest arch reg.
- in_rd_wr  in  1  instruction writes rd.
- fl_rd_en  out  1  free-list pop.
- fl_rd_data  in  PHYS_W  free-list head.
- fl_empty  in  1  free list empty.
- out_valid  out  1  renamed uop valid.
- out_ready  in  1  downstream accepts.
- out_prs1, out_prs2  out  PHYS_W  renamed sources.
- out_prd  out  PHYS_W  allocated dest.
- out_old_prd  out  PHYS_W  previous mapping of rd.
- out_rd_wr  out  1  uop allocates a dest.
- commit_valid  in  NUM_COMMIT  commit lane valid.
- commit_rd_wr  in  NUM_COMMIT  committed uop had a dest.
- commit_ard  in  NUM_COMMIT x ARCH_W  committed arch dest.
- commit_prd  in  NUM_COMMIT x PHYS_W  committed new phys dest.
- commit_old_prd  in  NUM_COMMIT x PHYS_W  phys reg to free.
- fl_wr_en  out  NUM_COMMIT  free-list push lanes.
- fl_wr_data  out  NUM_COMMIT x PHYS_W  freed phys regs.

Behaviour:
- Reset: RAT[i]=i for all arch regs; out_valid=0; all out_* data=0; fl_wr_en=0; fl_wr_data=0; fl_rd_en=0. Reset mid-operation discards the held uop.
- Handshake:
  - in_ready = (!out_valid | out_ready) & !fl_empty & !flush.
  - in_ready is conservative: the stage stalls on fl_empty even when in_rd_wr=0.
  - accept = in_valid & in_ready.
- On accept:
  - out_prs1=RAT[in_rs1] and out_prs2=RAT[in_rs2], read before this cycle's RAT write. An rs==rd in the same instruction therefore sees the old mapping.
  - Allocation applies when in_rd_wr & (in_rd!=0):
    - fl_rd_en=1 (combinational, same cycle).
    - out_prd=fl_rd_data; out_old_prd=RAT[in_rd]; out_rd_wr=1.
    - RAT[in_rd]<=fl_rd_data.
  - Otherwise: fl_rd_en=0; out_prd=0; out_old_prd=0; out_rd_wr=0.
  - Arch x0 is never remapped; RAT[0] stays 0.
- Latency: 1 cycle, accept to out_valid.
- Output register holds stable while out_valid & !out_ready.
- Back-to-back accepts are allowed when out_ready=1.
- Free path:
  - fl_wr_en[i] <= commit_valid[i] & commit_rd_wr[i] & (commit_ard[i]!=0).
  - fl_wr_data[i] <= commit_old_prd[i].
  - This path is 1-cycle registered, independent of flush and stalls.
- Flush:
  - out_valid<=0 next cycle.
  - No accept and no pop in the flush cycle.
  - The free-path register still updates.
  - Registers allocated to flushed uops are not reclaimed by this block; free-list recovery belongs to the ROB walk.

Optional Feature:
- Macro: RENAME_COMMIT_RAT_EN.
- Defined:
  - A committed RAT (CRAT) is added, reset to identity.
  - Per lane with commit_valid[i] & commit_rd_wr[i] & ard!=0: CRAT[commit_ard[i]]<=commit_prd[i]. Lane 1 wins on equal ard.
  - On flush: RAT<=CRAT, including that cycle's commit updates.
- Undefined:
  - No CRAT exists; commit_ard and commit_prd are ignored.
  - flush leaves the RAT unchanged.

Test Plan:
- Reset, then rename rs1=3, rs2=4, rd=5 with fl_rd_data=32 → next cycle out_prs1=3, out_prs2=4, out_prd=32, out_old_prd=5; fl_rd_en=1 for exactly one cycle.
- Follow-up rs1=5, rd=5, fl_rd_data=33 → out_prs1=32, out_old_prd=32, out_prd=33; RAT[5]=33.
- rd=0 with in_rd_wr=1 → fl_rd_en=0, out_rd_wr=0, RAT unchanged; in_rd_wr=0 likewise.
- fl_empty=1 → in_ready=0, no pop; out_ready=0 with out_valid=1 → outputs held and in_ready=0 for 3 cycles.
- commit_valid=2'b11, old_prd={7,9}, ard={1,2} → next cycle fl_wr_en=2'b11, fl_wr_data={7,9}. With ard[0]=0 → fl_wr_en[0]=0.
- With RENAME_COMMIT_RAT_EN: rename rd=5→32, commit (ard=5, prd=40), then flush → a subsequent rs1=5 reads 40. Without the macro → reads 32.
